// File: rtl/bit_unstuffer_pkg.sv
// ---------------------------------------------------------------------------
// bit_unstuffer_pkg
// Shared USB bit-level definitions for the transmit-side stuffer and the
// receive-side unstuffer: state enums and default packet-framing constants.
// No ports (package).
// ---------------------------------------------------------------------------
package bit_unstuffer_pkg;

    // Default framing: an 8-bit PID leads every packet, and six consecutive
    // ones are always followed by one inserted zero on the wire.
    localparam int DEF_PID_BITS = 8;
    localparam int DEF_MAX_ONES = 6;

    // Encoder side: idle, sending payload, inserting a stuff zero.
    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_SEND,
        ENC_INSERT
    } stuff_state_t;

    // Decoder side: the PID is passed through untouched except that its last
    // bit seeds the ones run; after that, runs are tracked and stuff bits
    // are removed or flagged.
    typedef enum logic [2:0] {
        IDLE,
        PASS_PID,
        COUNT_ONES,
        DROP_STUFF,
        ERROR
    } unstuff_state_t;

endpackage

// File: rtl/bit_unstuffer_fsm.sv
// ---------------------------------------------------------------------------
// bit_unstuffer_fsm
// Control half of the receive-side bit unstuffer. Holds the state register
// and decodes, for each incoming bit, whether it is forwarded, dropped or
// flagged, and how the PID-bit and ones-run counters must move.
// Ports:
//   clock, reset_n        : clock, synchronous active-low reset
//   in_valid, in_bit      : received bit stream
//   ones_cnt, bit_cnt     : current counter values from the datapath
//   fwd                   : forward in_bit as a payload bit
//   err, done             : stuff violation / clean end of packet
//   ones_inc/clr/load     : ones-run counter controls (load takes in_bit)
//   bit_inc, bit_clr      : PID bit counter controls
//   receiving             : state is not IDLE
// ---------------------------------------------------------------------------
module bit_unstuffer_fsm
    import bit_unstuffer_pkg::*;
#(
    parameter int PID_BITS = DEF_PID_BITS,
    parameter int MAX_ONES = DEF_MAX_ONES,
    localparam int OW = $clog2(MAX_ONES + 1),
    localparam int BW = $clog2(PID_BITS + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_bit,
    input  logic [OW-1:0] ones_cnt,
    input  logic [BW-1:0] bit_cnt,
    output logic          fwd,
    output logic          err,
    output logic          done,
    output logic          ones_inc,
    output logic          ones_clr,
    output logic          ones_load,
    output logic          bit_inc,
    output logic          bit_clr,
    output logic          receiving
);

    localparam logic [BW-1:0] PID_LAST  = BW'(PID_BITS - 1);
    localparam logic [OW-1:0] ONES_LAST = OW'(MAX_ONES - 1);

    unstuff_state_t state, next_state;

    // State register; reset always lands in IDLE so a packet cut short by
    // reset is simply abandoned.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. Every return to IDLE clears both
    // counters so the next packet starts from PID bit 0 with no ones run.
    always_comb begin
        next_state = state;
        fwd        = 1'b0;
        err        = 1'b0;
        done       = 1'b0;
        ones_inc   = 1'b0;
        ones_clr   = 1'b0;
        ones_load  = 1'b0;
        bit_inc    = 1'b0;
        bit_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    fwd        = 1'b1;
                    bit_inc    = 1'b1;
                    next_state = PASS_PID;
                end
            end
            PASS_PID: begin
                if (!in_valid) begin
                    done       = 1'b1;
                    ones_clr   = 1'b1;
                    bit_clr    = 1'b1;
                    next_state = IDLE;
                end else begin
                    fwd     = 1'b1;
                    bit_inc = 1'b1;
                    // Only the final PID bit is allowed to start a ones run.
                    if (bit_cnt == PID_LAST) begin
                        ones_load  = 1'b1;
                        next_state = COUNT_ONES;
                    end
                end
            end
            COUNT_ONES: begin
                if (!in_valid) begin
                    done       = 1'b1;
                    ones_clr   = 1'b1;
                    bit_clr    = 1'b1;
                    next_state = IDLE;
                end else begin
                    fwd = 1'b1;
                    if (in_bit) begin
                        ones_inc = 1'b1;
                        if (ones_cnt == ONES_LAST) begin
                            next_state = DROP_STUFF;
                        end
                    end else begin
                        ones_clr = 1'b1;
                    end
                end
            end
            DROP_STUFF: begin
                if (!in_valid) begin
                    // A packet ending where a stuff bit was due is still clean.
                    done       = 1'b1;
                    ones_clr   = 1'b1;
                    bit_clr    = 1'b1;
                    next_state = IDLE;
                end else if (in_bit) begin
                    err        = 1'b1;
                    next_state = ERROR;
                end else begin
                    ones_clr   = 1'b1;
                    next_state = COUNT_ONES;
                end
            end
            ERROR: begin
                if (!in_valid) begin
                    ones_clr   = 1'b1;
                    bit_clr    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign receiving = (state != IDLE);

endmodule

// File: rtl/bit_unstuffer.sv
// ---------------------------------------------------------------------------
// bit_unstuffer
// Receive-side USB bit unstuffer. Passes the PID through, tracks runs of
// ones in the rest of the packet, removes the zero inserted after each run
// of MAX_ONES ones and flags a one in that slot as a stuff error. All data
// outputs are registered: one cycle from input sample to output.
// Ports:
//   clock, reset_n  : clock, synchronous active-low reset
//   in_valid,in_bit : decoded bit stream, in_valid low ends the packet
//   out_bit         : unstuffed bit (0 when out_valid is 0)
//   out_valid       : out_bit carries a payload bit
//   stuff_err       : one-cycle pulse on a stuff violation
//   bu_receiving    : packet in progress
//   bu_done         : one-cycle pulse after a packet ends cleanly
// ---------------------------------------------------------------------------
module bit_unstuffer
    import bit_unstuffer_pkg::*;
#(
    parameter int PID_BITS = DEF_PID_BITS,
    parameter int MAX_ONES = DEF_MAX_ONES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    input  logic in_bit,
    output logic out_bit,
    output logic out_valid,
    output logic stuff_err,
    output logic bu_receiving,
    output logic bu_done
);

    localparam int OW = $clog2(MAX_ONES + 1);
    localparam int BW = $clog2(PID_BITS + 1);

    logic [OW-1:0] ones_cnt;
    logic [BW-1:0] bit_cnt;
    logic fwd, err, done;
    logic ones_inc, ones_clr, ones_load;
    logic bit_inc, bit_clr;

    bit_unstuffer_fsm #(
        .PID_BITS(PID_BITS),
        .MAX_ONES(MAX_ONES)
    ) u_fsm (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .ones_cnt (ones_cnt),
        .bit_cnt  (bit_cnt),
        .fwd      (fwd),
        .err      (err),
        .done     (done),
        .ones_inc (ones_inc),
        .ones_clr (ones_clr),
        .ones_load(ones_load),
        .bit_inc  (bit_inc),
        .bit_clr  (bit_clr),
        .receiving(bu_receiving)
    );

    // Ones-run counter. Load seeds the run from the last PID bit; clear wins
    // so a stuffed zero or end of packet always restarts the run at 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ones_cnt <= '0;
        end else if (ones_clr) begin
            ones_cnt <= '0;
        end else if (ones_load) begin
            ones_cnt <= OW'(in_bit);
        end else if (ones_inc) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end

    // PID bit counter. It stops advancing once the PID is past, so it
    // cannot wrap however long the payload is.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_cnt <= '0;
        end else if (bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Output registers. out_bit is gated by the forward decision so it reads
    // 0 on every cycle that carries no payload.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            stuff_err <= 1'b0;
            bu_done   <= 1'b0;
        end else begin
            out_bit   <= fwd & in_bit;
            out_valid <= fwd;
            stuff_err <= err;
            bu_done   <= done;
        end
    end

endmodule
